systolic_out_drain: RTL and testbench

//  Downstream of the systolic output buffer. On start, reads num_rows final-tile rows
//  (N_SIZE x DATAWIDTH_output accumulators each) from address 0 upward.

---
 rtl/systolic_out_drain_if.sv | 13 +
 rtl/systolic_out_drain.sv | 184 ++++++++++++++++++
 tb/tb_systolic_out_drain.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_out_drain_if.sv
// Output stream interface of the systolic output drain.
// The master drives packed requantized rows; the slave applies backpressure via out_ready.
interface systolic_out_drain_if #(
   parameter int DATAWIDTH = 8,
   parameter int N_SIZE    = 32
);
   logic [DATAWIDTH*N_SIZE-1:0] out_data;
   logic                        out_valid;
   logic                        out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/systolic_out_drain.sv
// Systolic output drain.
// On start, reads num_rows accumulator rows from the output buffer (address 0 upward).
// Each lane is requantized to DATAWIDTH signed (rounding shift, then saturate).
// Rows pass through a small FIFO and stream out over a valid/ready interface.
// The read issue logic counts in-flight reads, so the FIFO can never overflow.
// Optional build macro: DRAIN_RELU_EN clamps negative lanes to zero after saturation.
// Latency is the same in both builds.
module systolic_out_drain #(
   parameter int DATAWIDTH        = 8,
   parameter int DATAWIDTH_output = 32,
   parameter int N_SIZE           = 32,
   parameter int ADDR_WIDTH       = 10,
   parameter int SHIFT_WIDTH      = 5,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [ADDR_WIDTH:0]                num_rows,
   input  logic [SHIFT_WIDTH-1:0]             shift_amt,
   output logic [ADDR_WIDTH-1:0]              rd_addr_outbuffer,
   input  logic [DATAWIDTH_output*N_SIZE-1:0] rd_data_outbuffer,
   systolic_out_drain_if.master               out_if,
   output logic                               busy,
   output logic                               done
);

   localparam int ROW_W = DATAWIDTH * N_SIZE;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 2;
   localparam int ACC_W = DATAWIDTH_output + 1;

   localparam logic [ADDR_WIDTH:0]       ROW_ONE = 1;
   localparam logic [PTR_W-1:0]          PTR_ONE = 1;
   localparam logic [PTR_W:0]            CNT_ONE = 1;
   localparam logic [SHIFT_WIDTH-1:0]    S_ONE   = 1;
   localparam logic signed [ACC_W-1:0]   ACC_ONE = 1;
   localparam logic signed [DATAWIDTH-1:0] RES_MAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
   localparam logic signed [DATAWIDTH-1:0] RES_MIN = {1'b1, {(DATAWIDTH-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]   SAT_MAX = ACC_W'(RES_MAX);
   localparam logic signed [ACC_W-1:0]   SAT_MIN = ACC_W'(RES_MIN);

   typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

   state_t                 state;
   logic [ADDR_WIDTH:0]    rows_q;
   logic [ADDR_WIDTH:0]    issued;
   logic [SHIFT_WIDTH-1:0] shift_q;
   logic                   rd_pend;     // address registered, data arrives next cycle
   logic                   data_vld;    // rd_data_outbuffer holds a requested row this cycle

   logic [ROW_W-1:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         fifo_count;

   logic [ROW_W-1:0]       req_row;
   logic [CNT_W-1:0]       occupancy;
   logic                   fifo_valid;
   logic                   push;
   logic                   pop;
   logic                   can_issue;
   logic                   last_beat;

   // Rounding right shift in ACC_W bits, saturation, optional ReLU.
   function automatic logic [DATAWIDTH-1:0] requant_lane(
      input logic signed [DATAWIDTH_output-1:0] x,
      input logic [SHIFT_WIDTH-1:0]             s
   );
      logic signed [ACC_W-1:0] ext;
      logic signed [ACC_W-1:0] rnd;
      logic signed [ACC_W-1:0] y;
      logic [DATAWIDTH-1:0]    res;
      ext = ACC_W'(x);
      rnd = '0;
      if (s != '0) rnd = ACC_ONE << (s - S_ONE);
      y = (ext + rnd) >>> s;
      if (y > SAT_MAX)      res = RES_MAX;
      else if (y < SAT_MIN) res = RES_MIN;
      else                  res = y[DATAWIDTH-1:0];
`ifdef DRAIN_RELU_EN
      if (y[ACC_W-1]) res = '0;
`else
`endif
      return res;
   endfunction

   // Requantize every lane of the row currently on the buffer read port.
   // NOTE: combinational outputs get a default first so no latch is inferred.
   always_comb begin
      req_row = '0;
      for (int i = 0; i < N_SIZE; i++) begin
         req_row[i*DATAWIDTH +: DATAWIDTH] =
            requant_lane(rd_data_outbuffer[i*DATAWIDTH_output +: DATAWIDTH_output], shift_q);
      end
   end

   assign fifo_valid = (fifo_count != '0);
   assign push       = data_vld;
   assign pop        = fifo_valid && out_if.out_ready;
   assign occupancy  = CNT_W'(fifo_count) + CNT_W'(rd_pend) + CNT_W'(data_vld);
   assign can_issue  = (occupancy + CNT_W'(1)) <= (CNT_W'(FIFO_DEPTH) + CNT_W'(pop));
   assign last_beat  = !rd_pend && !data_vld &&
                       ((fifo_count == '0) || ((fifo_count == CNT_ONE) && pop));

   assign out_if.out_valid = fifo_valid;
   assign out_if.out_data  = fifo_valid ? fifo_mem[rd_ptr] : '0;

   // Control FSM: start latch, read-address issue, completion and done pulse.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         rows_q            <= '0;
         issued            <= '0;
         shift_q           <= '0;
         rd_pend           <= 1'b0;
         rd_addr_outbuffer <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         done    <= 1'b0;
         rd_pend <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rows_q  <= num_rows;
                  shift_q <= shift_amt;
                  busy    <= 1'b1;
                  if (num_rows == '0) begin
                     state <= FLUSH;
                  end else begin
                     state             <= READ;
                     rd_addr_outbuffer <= '0;
                     issued            <= ROW_ONE;
                     rd_pend           <= 1'b1;
                  end
               end
            end
            READ: begin
               if (issued == rows_q) begin
                  state <= FLUSH;
               end else if (can_issue) begin
                  rd_addr_outbuffer <= issued[ADDR_WIDTH-1:0];
                  issued            <= issued + ROW_ONE;
                  rd_pend           <= 1'b1;
                  if ((issued + ROW_ONE) == rows_q) state <= FLUSH;
               end
            end
            FLUSH: begin
               if (last_beat) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-data tracking and FIFO pointers/count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_vld   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         data_vld <= rd_pend;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
         else if (pop && !push) fifo_count <= fifo_count - CNT_ONE;
      end
   end

   // FIFO storage write.
   // NOTE: storage is not reset; out_data is gated by out_valid so stale entries never show.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= req_row;
   end

endmodule

// File: tb/tb_systolic_out_drain.sv
// Directed self-checking bench for systolic_out_drain.
// Models the output buffer as a synchronous-read memory and checks every beat
// against rows whose requantized values are precomputed by the bench.
module tb_systolic_out_drain;

   localparam int DATAWIDTH        = 8;
   localparam int DATAWIDTH_output = 32;
   localparam int N_SIZE           = 32;
   localparam int ADDR_WIDTH       = 10;
   localparam int SHIFT_WIDTH      = 5;
   localparam int FIFO_DEPTH       = 4;
   localparam int OUT_W            = DATAWIDTH * N_SIZE;
   localparam int IN_W             = DATAWIDTH_output * N_SIZE;
   localparam int DEPTH            = 1 << ADDR_WIDTH;

`ifdef DRAIN_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   start;
   logic [ADDR_WIDTH:0]    num_rows;
   logic [SHIFT_WIDTH-1:0] shift_amt;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [IN_W-1:0]        rd_data;
   logic                   busy;
   logic                   done;
   logic                   out_ready;
   logic                   out_valid;
   logic [OUT_W-1:0]       out_data;

   logic [IN_W-1:0]        buf_mem  [DEPTH];
   logic [OUT_W-1:0]       exp_rows [DEPTH];

   int total = 0;
   int bad   = 0;
   logic [15:0] lfsr = 16'hACE1;

   int r_first_k, r_last_k, r_done_k, r_beats, r_done_cnt, r_busy;
   int r_steps, r_step_errs, r_changes;
   logic [ADDR_WIDTH-1:0] r_first_addr;

   systolic_out_drain_if #(.DATAWIDTH(DATAWIDTH), .N_SIZE(N_SIZE)) out_if ();

   assign out_if.out_ready = out_ready;
   assign out_valid        = out_if.out_valid;
   assign out_data         = out_if.out_data;

   systolic_out_drain #(
      .DATAWIDTH(DATAWIDTH), .DATAWIDTH_output(DATAWIDTH_output), .N_SIZE(N_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .shift_amt(shift_amt),
      .rd_addr_outbuffer(rd_addr), .rd_data_outbuffer(rd_data),
      .out_if(out_if), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous-read output buffer: data valid the cycle after the address.
   always @(posedge clk) rd_data <= buf_mem[rd_addr];

   task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Rows with small values; shift 0 keeps them unchanged (ReLU zeroes negatives).
   task automatic fill_pattern(input int rows);
      int v;
      for (int r = 0; r < rows; r++) begin
         for (int i = 0; i < N_SIZE; i++) begin
            v = ((r * 13 + i * 7) % 101) - 50;
            buf_mem[r][i*DATAWIDTH_output +: DATAWIDTH_output] = 32'(v);
            exp_rows[r][i*DATAWIDTH +: DATAWIDTH] = (RELU && v < 0) ? 8'd0 : 8'(v);
         end
      end
   endtask

   // Starts a drain at the current negedge and follows it until done.
   // mode 0: ready high; 1: pseudo-random ready; 2: ready low 12 cycles then random.
   task automatic run_drain(input int rows, input logic [SHIFT_WIDTH-1:0] sh, input int mode,
                            input int restart_k, input int budget);
      logic [ADDR_WIDTH-1:0] prev;
      bit fin;
      int pv, pd;
      r_first_k = -1; r_last_k = -1; r_done_k = -1; r_beats = 0; r_done_cnt = 0; r_busy = 0;
      r_steps = 0; r_step_errs = 0; r_changes = 0;
      prev      = rd_addr;
      num_rows  = (ADDR_WIDTH+1)'(rows);
      shift_amt = sh;
      start     = 1'b1;
      fin       = 1'b0;
      for (int k = 0; k < budget && !fin; k++) begin
         @(negedge clk);
         start = (k == restart_k);
         if (k == restart_k) num_rows = 2;
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 2 && k < 12) out_ready = 1'b0;
         else begin
            lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = lfsr[0];
         end
         if (k == 0) r_first_addr = rd_addr;
         if (rd_addr != prev) begin
            r_changes++;
            if (k > 0) begin
               r_steps++;
               if (rd_addr != prev + ADDR_WIDTH'(1)) r_step_errs++;
            end
         end
         prev = rd_addr;
         if (busy) r_busy++;
         if (mode == 2 && k == 11) begin
            check("stall_addr", rd_addr, 3);
            check("stall_valid", out_valid, 1);
         end
         if (out_valid) begin
            if (r_first_k < 0) r_first_k = k;
            if (r_beats < rows) check(out_ready ? "beat" : "hold", out_data, exp_rows[r_beats]);
            else check("extra_beat", out_valid, 0);
            if (out_ready) begin
               r_last_k = k;
               r_beats++;
            end
         end
         if (done) begin
            r_done_cnt++;
            r_done_k = k;
            check("done_after_beats", r_beats, rows);
            fin = 1'b1;
         end
      end
      start     = 1'b0;
      out_ready = 1'b1;
      check("done_seen", r_done_cnt, 1);
      check("beat_count", r_beats, rows);
      pv = 0; pd = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) pv++;
         if (done) pd++;
      end
      check("post_valid", pv, 0);
      check("post_done", pd, 0);
   endtask

   initial begin
      int in1 [4];
      int ex1 [4];
      int in2 [5];
      int ex2 [5];

      rst_n = 1'b0; start = 1'b0; num_rows = '0; shift_amt = '0; out_ready = 1'b1;
      for (int r = 0; r < DEPTH; r++) begin
         buf_mem[r]  = '0;
         exp_rows[r] = '0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_addr", rd_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Rounding and saturation, shift 4, ready high
      in1 = '{24, -24, 40000, -40000};
      if (RELU) ex1 = '{2, 0, 127, 0};
      else      ex1 = '{2, -1, 127, -128};
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N_SIZE; i++) begin
            buf_mem[r][i*DATAWIDTH_output +: DATAWIDTH_output] = 32'(in1[(r + i) % 4]);
            exp_rows[r][i*DATAWIDTH +: DATAWIDTH] = 8'(ex1[(r + i) % 4]);
         end
      end
      run_drain(4, 5'd4, 0, -1, 50);
      check("t1_first_valid_k", r_first_k, 2);
      check("t1_last_beat_k", r_last_k, 5);
      check("t1_done_k", r_done_k, 6);
      check("t1_busy_cycles", r_busy, 6);
      check("t1_first_addr", r_first_addr, 0);
      check("t1_addr_steps", r_steps, 3);
      check("t1_step_errs", r_step_errs, 0);
      check("t1_final_addr", rd_addr, 3);

      // Shift 0 saturation (and ReLU when enabled)
      in2 = '{127, 128, -129, -128, -5};
      if (RELU) ex2 = '{127, 127, 0, 0, 0};
      else      ex2 = '{127, 127, -128, -128, -5};
      for (int i = 0; i < N_SIZE; i++) begin
         buf_mem[0][i*DATAWIDTH_output +: DATAWIDTH_output] = 32'(in2[i % 5]);
         exp_rows[0][i*DATAWIDTH +: DATAWIDTH] = 8'(ex2[i % 5]);
      end
      run_drain(1, 5'd0, 0, -1, 50);
      check("t2_first_valid_k", r_first_k, 2);

      // Empty drain
      run_drain(0, 5'd0, 0, -1, 20);
      check("t4_addr_changes", r_changes, 0);
      check("t4_no_valid", r_first_k, -1);
      check("t4_busy_cycles", r_busy, 1);
      check("t4_done_k", r_done_k, 1);

      // Backpressure: stall first, then pseudo-random ready
      fill_pattern(16);
      run_drain(16, 5'd0, 2, -1, 400);
      check("t3_step_errs", r_step_errs, 0);
      check("t3_final_addr", rd_addr, 15);

      // Second start during a drain is ignored
      run_drain(8, 5'd0, 1, 3, 300);
      check("t5_step_errs", r_step_errs, 0);
      check("t5_final_addr", rd_addr, 7);

      // Asynchronous reset mid-drain
      num_rows = 8; shift_amt = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_addr", rd_addr, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fresh drain after reset starts at address 0
      run_drain(3, 5'd0, 0, -1, 50);
      check("t5_post_rst_first_addr", r_first_addr, 0);
      check("t5_post_rst_first_k", r_first_k, 2);

      // Full depth
      fill_pattern(DEPTH);
      run_drain(DEPTH, 5'd0, 0, -1, DEPTH + 100);
      check("t6_first_addr", r_first_addr, 0);
      check("t6_addr_steps", r_steps, DEPTH - 1);
      check("t6_step_errs", r_step_errs, 0);
      check("t6_final_addr", rd_addr, DEPTH - 1);
      check("t6_no_bubbles", r_last_k - r_first_k, DEPTH - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
